pc_trace_monitor: RTL and testbench

Synthesisable execution observer for the single-cycle RISC-V core. It samples the program counter every enabled cycle into a circular trace buffer and counts executed cycles. It detects halt conditions (PC stall or breakpoint hit) and freezes capture with the final PC latched. It replaces end-of-run PC printing with a parametrised, readable-back trace usable in simulation and on hardware.

---
 rtl/pc_trace_monitor.sv | 156 +++++++++++++++
 tb/tb_pc_trace_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_trace_monitor.sv
// pc_trace_monitor: samples the core PC into a circular trace buffer, counts
// samples, and freezes capture on a PC stall or breakpoint hit.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset/clear; next sample has no predecessor
// RUN     | capturing; samples compared against the previous PC
// HALTED  | capture frozen; trace and final_pc held for readback
module pc_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [XLEN-1:0]            pc_atual,
  input  logic                       bp_en,
  input  logic [XLEN-1:0]            bp_addr,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [XLEN-1:0]            rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       halted,
  output logic [1:0]                 halt_cause,
  output logic [XLEN-1:0]            final_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(HALT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             halted_q, halted_d;
  logic [1:0]       halt_cause_q, halt_cause_d;
  logic [XLEN-1:0]  final_pc_q, final_pc_d;
  logic [XLEN-1:0]  rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [XLEN-1:0]  mem [DEPTH];

  logic             sample;
  logic [RW-1:0]    rep_next;
  logic             stall_hit;
  logic             bp_hit;
  logic [PW-1:0]    rd_addr;

  // Sample qualification, halt detection and next-state computation.
  always_comb begin
    sample    = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && enable && !clear;
    // In IDLE there is no previous sample, so the repeat count restarts at 0.
    rep_next  = ((state_q == ST_RUN) && (pc_atual == prev_pc_q)) ? rep_q + RW'(1) : '0;
    stall_hit = (rep_next == RW'(HALT_CYCLES));
    bp_hit    = bp_en && (pc_atual == bp_addr);
    // Readback uses the pre-write pointer, so a same-edge write is not seen yet.
    rd_addr   = wr_ptr_q - PW'(1) - rd_idx;

    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    cycle_count_d = cycle_count_q;
    rep_d         = rep_q;
    prev_pc_d     = prev_pc_q;
    halted_d      = halted_q;
    halt_cause_d  = halt_cause_q;
    final_pc_d    = final_pc_q;
    rd_data_d     = mem[rd_addr];
    rd_valid_d    = ({1'b0, rd_idx} < count_q);

    if (clear) begin
      state_d       = ST_IDLE;
      wr_ptr_d      = '0;
      count_d       = '0;
      cycle_count_d = '0;
      rep_d         = '0;
      prev_pc_d     = '0;
      halted_d      = 1'b0;
      halt_cause_d  = 2'b00;
      final_pc_d    = '0;
    end else if (sample) begin
      state_d   = ST_RUN;
      wr_ptr_d  = wr_ptr_q + PW'(1);
      rep_d     = rep_next;
      prev_pc_d = pc_atual;
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end
      if (!(&cycle_count_q)) begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
      end
      if (stall_hit || bp_hit) begin
        state_d      = ST_HALTED;
        halted_d     = 1'b1;
        halt_cause_d = {bp_hit, stall_hit};
        final_pc_d   = pc_atual;
      end
    end
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      cycle_count_q <= '0;
      rep_q         <= '0;
      prev_pc_q     <= '0;
      halted_q      <= 1'b0;
      halt_cause_q  <= 2'b00;
      final_pc_q    <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      cycle_count_q <= cycle_count_d;
      rep_q         <= rep_d;
      prev_pc_q     <= prev_pc_d;
      halted_q      <= halted_d;
      halt_cause_q  <= halt_cause_d;
      final_pc_q    <= final_pc_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Trace RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (sample) begin
      mem[wr_ptr_q] <= pc_atual;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign cycle_count = cycle_count_q;
  assign halted      = halted_q;
  assign halt_cause  = halt_cause_q;
  assign final_pc    = final_pc_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench for pc_trace_monitor with default parameters.
module tb_pc_trace_monitor;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        enable;
  logic [31:0] pc_atual;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic [31:0] cycle_count;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] final_pc;

  int checks   = 0;
  int failures = 0;

  pc_trace_monitor #(
    .XLEN(32), .DEPTH(16), .HALT_CYCLES(4), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .pc_atual(pc_atual), .bp_en(bp_en), .bp_addr(bp_addr),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .cycle_count(cycle_count), .halted(halted),
    .halt_cause(halt_cause), .final_pc(final_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [31:0] pc);
    enable   = 1'b1;
    pc_atual = pc;
    tick();
  endtask

  task automatic idle_read(input logic [3:0] idx);
    enable = 1'b0;
    rd_idx = idx;
    tick();
  endtask

  task automatic do_clear();
    clear  = 1'b1;
    enable = 1'b0;
    tick();
    clear  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; enable = 1'b1; pc_atual = 32'h0;
    bp_en = 1'b0; bp_addr = 32'h0; rd_idx = 4'd0;

    // Reset held low while PC toggles with enable high.
    for (int i = 0; i < 3; i++) begin
      pc_atual = 32'h100 + 32'(i * 4);
      tick();
    end
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    enable = 1'b0;
    reset  = 1'b1;
    tick();
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_halted", 64'(halted), 64'd0);

    // Wrap: 20 samples 0,4,...,76.
    for (int i = 0; i < 20; i++) smp(32'(i * 4));
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_cycle", 64'(cycle_count), 64'd20);
    idle_read(4'd0);
    chk("wrap_rd0", 64'(rd_data), 64'd76);
    chk("wrap_rv0", 64'(rd_valid), 64'd1);
    idle_read(4'd15);
    chk("wrap_rd15", 64'(rd_data), 64'd16);
    chk("wrap_rv15", 64'(rd_valid), 64'd1);
    chk("gap_count", 64'(count), 64'd16);
    chk("gap_cycle", 64'(cycle_count), 64'd20);

    // Clear with enable on the same edge: no sample.
    clear = 1'b1; enable = 1'b1; pc_atual = 32'h99;
    tick();
    clear = 1'b0;
    chk("clr_en_count", 64'(count), 64'd0);
    chk("clr_en_cycle", 64'(cycle_count), 64'd0);
    idle_read(4'd0);
    chk("clr_rv", 64'(rd_valid), 64'd0);

    // Stall halt: 0,4,8,8,8,8,8 then 12.
    smp(32'd0); smp(32'd4); smp(32'd8); smp(32'd8); smp(32'd8); smp(32'd8);
    chk("stall_pre_halted", 64'(halted), 64'd0);
    smp(32'd8);
    chk("stall_halted", 64'(halted), 64'd1);
    chk("stall_cycle", 64'(cycle_count), 64'd7);
    chk("stall_final", 64'(final_pc), 64'd8);
    chk("stall_cause", 64'(halt_cause), 64'b01);
    rd_idx = 4'd0;
    smp(32'd12);
    chk("stall_frozen_cycle", 64'(cycle_count), 64'd7);
    chk("stall_frozen_count", 64'(count), 64'd7);
    chk("stall_rd0", 64'(rd_data), 64'd8);
    idle_read(4'd6);
    chk("stall_rd6", 64'(rd_data), 64'd0);
    chk("stall_rv6", 64'(rd_valid), 64'd1);
    idle_read(4'd7);
    chk("stall_rv7", 64'(rd_valid), 64'd0);
    do_clear();

    // Breakpoint at 0x20.
    bp_en = 1'b1; bp_addr = 32'h20;
    for (int i = 0; i < 8; i++) smp(32'(i * 4));
    chk("bp_pre_halted", 64'(halted), 64'd0);
    smp(32'h20);
    chk("bp_halted", 64'(halted), 64'd1);
    chk("bp_final", 64'(final_pc), 64'h20);
    chk("bp_cause", 64'(halt_cause), 64'b10);
    chk("bp_count", 64'(count), 64'd9);
    do_clear();
    bp_en = 1'b0;
    chk("bpclr_halted", 64'(halted), 64'd0);
    chk("bpclr_cause", 64'(halt_cause), 64'd0);
    chk("bpclr_final", 64'(final_pc), 64'd0);
    chk("bpclr_count", 64'(count), 64'd0);
    chk("bpclr_cycle", 64'(cycle_count), 64'd0);
    rd_idx = 4'd0;
    smp(32'h100);
    chk("restart_count", 64'(count), 64'd1);
    chk("restart_cycle", 64'(cycle_count), 64'd1);
    chk("restart_halted", 64'(halted), 64'd0);
    // Same-edge write and read: pre-write newest, new value one cycle later.
    smp(32'h104);
    chk("rw_same_edge", 64'(rd_data), 64'h100);
    idle_read(4'd0);
    chk("rw_next", 64'(rd_data), 64'h104);
    do_clear();

    // Simultaneous stall and breakpoint on the 6th sample.
    bp_addr = 32'h4; bp_en = 1'b0;
    smp(32'd0); smp(32'd4); smp(32'd4); smp(32'd4); smp(32'd4);
    chk("sim_pre_halted", 64'(halted), 64'd0);
    bp_en = 1'b1;
    smp(32'd4);
    bp_en = 1'b0;
    chk("sim_halted", 64'(halted), 64'd1);
    chk("sim_cause", 64'(halt_cause), 64'b11);
    chk("sim_final", 64'(final_pc), 64'd4);
    chk("sim_cycle", 64'(cycle_count), 64'd6);
    idle_read(4'd0);
    chk("sim_rd0", 64'(rd_data), 64'd4);

    // Asynchronous reset pulse mid-cycle, no clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_cause", 64'(halt_cause), 64'd0);
    chk("arst_final", 64'(final_pc), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_cycle", 64'(cycle_count), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    reset = 1'b1;
    smp(32'h40);
    chk("post_arst_count", 64'(count), 64'd1);
    chk("post_arst_cycle", 64'(cycle_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
